// File: rtl/alu_bcd_display.sv
// Serial binary-to-BCD converter for the ALU result display.
// Shift-and-add-3, one bit per clock; digits held until next completion.
module alu_bcd_display (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       blank_h,
    output logic       blank_t
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [11:0] work_q, work_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        blank_h_q, blank_h_d;
    logic        blank_t_q, blank_t_d;

    logic [11:0] adj;
    logic [19:0] shifted;

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        adj = work_q;
        for (int n = 0; n < 3; n++) begin
            if (work_q[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = work_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj, sh_q} << 1;

    // Next-state logic for the conversion sequencer and output registers.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        blank_h_d = blank_h_q;
        blank_t_d = blank_t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = bin;
                    work_d  = 12'd0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                work_d = shifted[19:8];
                sh_d   = shifted[7:0];
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    hund_d    = shifted[19:16];
                    tens_d    = shifted[15:12];
                    ones_d    = shifted[11:8];
                    blank_h_d = (shifted[19:16] == 4'd0);
                    blank_t_d = (shifted[19:16] == 4'd0)
                              && (shifted[15:12] == 4'd0);
                end
            end
        endcase
    end

    // State and output registers; reset shows a blanked 000.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= 8'd0;
            work_q    <= 12'd0;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hund_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            blank_h_q <= 1'b1;
            blank_t_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            blank_h_q <= blank_h_d;
            blank_t_q <= blank_t_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bcd_hundreds = hund_q;
    assign bcd_tens     = tens_q;
    assign bcd_ones     = ones_q;
    assign blank_h      = blank_h_q;
    assign blank_t      = blank_t_q;

endmodule

// File: tb/tb_alu_bcd_display.sv
// Self-checking bench for alu_bcd_display.
// Reference digits come from plain decimal division of the input.
module tb_alu_bcd_display;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       blank_h;
    logic       blank_t;

    int n_cmp;
    int n_bad;

    alu_bcd_display dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bin          (bin),
        .busy         (busy),
        .done         (done),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .blank_h      (blank_h),
        .blank_t      (blank_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
        check({tag, ".hund"}, int'(bcd_hundreds), 0);
        check({tag, ".tens"}, int'(bcd_tens), 0);
        check({tag, ".ones"}, int'(bcd_ones), 0);
        check({tag, ".blank_h"}, int'(blank_h), 1);
        check({tag, ".blank_t"}, int'(blank_t), 1);
    endtask

    task automatic check_digits(input string tag, input int v);
        check({tag, ".hund"}, int'(bcd_hundreds), v / 100);
        check({tag, ".tens"}, int'(bcd_tens), (v / 10) % 10);
        check({tag, ".ones"}, int'(bcd_ones), v % 10);
        check({tag, ".blank_h"}, int'(blank_h), (v < 100) ? 1 : 0);
        check({tag, ".blank_t"}, int'(blank_t), (v < 10) ? 1 : 0);
    endtask

    // mode 0: quiet inputs, 1: random bin/start noise, 2: bin=9/start at E3
    task automatic convert(input int v, input int mode, input string tag);
        bin   = 8'(v);
        start = 1'b1;
        tick();
        check({tag, ".E0.busy"}, int'(busy), 1);
        check({tag, ".E0.done"}, int'(done), 0);
        for (int i = 1; i <= 7; i++) begin
            start = 1'b0;
            if (mode == 1) begin
                bin   = 8'($urandom);
                start = 1'($urandom);
            end else if (mode == 2 && i == 3) begin
                bin   = 8'd9;
                start = 1'b1;
            end
            tick();
            check({tag, ".shift.busy"}, int'(busy), 1);
            check({tag, ".shift.done"}, int'(done), 0);
        end
        start = 1'b0;
        tick();
        check({tag, ".E8.busy"}, int'(busy), 0);
        check({tag, ".E8.done"}, int'(done), 1);
        check_digits({tag, ".E8"}, v);
        tick();
        check({tag, ".E9.done"}, int'(done), 0);
        check({tag, ".E9.busy"}, int'(busy), 0);
        check_digits({tag, ".E9"}, v);
    endtask

    initial begin
        int v;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        #3;
        check_reset_vals("por");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_vals("idle");

        convert(255, 0, "max");

        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        tick();
        reset = 1'b0;
        tick();
        check_reset_vals("post_rst");

        convert(7, 0, "seven");
        convert(0, 0, "zero");
        convert(40, 0, "forty");

        convert(128, 2, "lock");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lock.idle.busy", int'(busy), 0);
            check("lock.idle.done", int'(done), 0);
            check_digits("lock.hold", 128);
        end

        bin   = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort.busy_pre", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        tick();
        check_reset_vals("abort_hold");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort.no_done", int'(done), 0);
            check("abort.no_busy", int'(busy), 0);
        end
        check_reset_vals("abort_idle");
        convert(99, 0, "after_abort");

        bin   = 8'd42;
        start = 1'b1;
        tick();
        check("b2b.E0.busy", int'(busy), 1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 7; i++) begin
                tick();
                check("b2b.shift.busy", int'(busy), 1);
                check("b2b.shift.done", int'(done), 0);
            end
            tick();
            check("b2b.E8.busy", int'(busy), 0);
            check("b2b.E8.done", int'(done), 1);
            check_digits("b2b.E8", 42);
            if (k == 2) start = 1'b0;
            tick();
            check("b2b.E9.done", int'(done), 0);
            check("b2b.E9.busy", int'(busy), (k == 2) ? 0 : 1);
            check_digits("b2b.E9", 42);
        end

        for (int r = 0; r < 24; r++) begin
            v = int'($urandom_range(0, 255));
            convert(v, 1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_bcd_display.md
# alu_bcd_display

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit ALU result register. It takes the register's 8-bit value (0–255) on a start request and converts it to three decimal digits using shift-and-add-3, one bit per clock. It presents the digits, plus leading-zero blank flags, to the seg7 decoders driving HEX2/HEX1/HEX0.

## Interface
- No parameters; the input width is fixed at 8 bits and the output at 3 BCD digits.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  8  unsigned value to convert, normally the ALU register output.
- busy  output  1  registered; high while a conversion is in progress.
- done  output  1  registered; one-cycle pulse when new digits are published.
- bcd_hundreds  output  4  hundreds digit, range 0–2; bits [3:2] are always 0.
- bcd_tens  output  4  tens digit, range 0–9.
- bcd_ones  output  4  ones digit, range 0–9.
- blank_h  output  1  high when bcd_hundreds == 0.
- blank_t  output  1  high when bcd_hundreds == 0 and bcd_tens == 0.

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- State machine has two states, IDLE and SHIFT.
  - IDLE to SHIFT: on a clk edge with start = 1. At this edge:
    - copy bin into an 8-bit shift register;
    - clear the 12-bit BCD working register;
    - set the bit counter to 0;
    - set busy to 1.
  - SHIFT, every edge:
    - add 3 to each working nibble whose value is ≥ 5;
    - then shift {working, shift register} left by 1 as one 20-bit word;
    - increment the counter.
  - SHIFT to IDLE: on the edge that performs the 8th shift (counter == 7). At this edge:
    - load the output digits from the post-shift working register;
    - compute blank_h and blank_t from the new digits;
    - set done to 1 and busy to 0.
- The output digits and blank flags are registers. They change only on a completion edge or on reset, and otherwise hold their last result indefinitely.
- Changes on bin after the start edge do not affect the conversion in progress.
- A start asserted while in SHIFT is ignored, not queued.
- Start may be a held level: each time the block returns to IDLE, a new conversion begins on the next edge.
- Arithmetic:
  - The add-3 correction is applied per nibble before the shift, within the same cycle.
  - Working nibbles never exceed 4 bits.
  - For bin = 255 the result is hundreds = 2, tens = 5, ones = 5.

## Timing
- Call the edge that samples start E0.
  - After E0: busy = 1.
  - Edges E1 through E8 each perform one shift.
  - After E8: digits and blanks valid, done = 1, busy = 0, state = IDLE.
  - After E9: done = 0.
- Latency is 8 cycles from the sampled start to valid output.
- Minimum start-to-start period is 9 cycles. A start present at E9 is accepted in the same cycle that done is high.
- busy is high for exactly 8 cycles per conversion.
- Reset values: state = IDLE, busy = 0, done = 0, all digits = 0, blank_h = 1, blank_t = 1.
  - These are consistent with a displayed value of 000.
- Reset during SHIFT:
  - abort immediately, with no done pulse;
  - outputs go to their reset values;
  - after reset deasserts, the block waits in IDLE for a new start.
- Release of reset is synchronous in effect: start is not sampled on an edge where reset is high.

## Test plan
- Reset: assert reset mid-cycle with no clock edge → immediately busy = 0, done = 0, digits 0/0/0, blank_h = 1, blank_t = 1.
- Maximum value: bin = 8'hFF, single-cycle start at E0 → busy high after E0 through E8; after E8 digits 2/5/5, blank_h = 0, blank_t = 0, done high for exactly one cycle.
- Leading-zero blanking:
  - bin = 8'd7 → 0/0/7 with blank_h = 1, blank_t = 1;
  - then bin = 8'd0 → 0/0/0 with blank_h = 1, blank_t = 1;
  - then bin = 8'd40 → 0/4/0 with blank_h = 1, blank_t = 0.
- Input stability and busy lockout: bin = 8'd128, start at E0; at E3 drive bin = 8'd9 and start = 1 → result 1/2/8 after E8, exactly one done pulse, no second conversion.
- Reset mid-conversion: bin = 8'd200, start at E0; assert reset between E4 and E5 → outputs return to reset values and no done pulse occurs. Then release reset, bin = 8'd99, start → 0/9/9 after 8 cycles.
- Back-to-back: start held at 1 with bin = 8'd42 → done pulses at E8, E17, E26 (9-cycle period); digits stay at 0/4/2; busy low only in the single cycles after E8, E17 and E26.
